// File: rtl/framebuffer_writer.sv
// Write-side controller for the display framebuffer: turns a qualified camera pixel
// stream into frame-aligned, row-aligned BRAM writes with sticky framing error flags.
module framebuffer_writer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_capture_en,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_eol,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_err_clr,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_err_line,
    output logic              o_err_frame
);

    // col counts one past the row end to mark "dropping until eol"
    localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_line_q, err_line_d;
    logic                err_frame_q, err_frame_d;

    logic                accept;
    logic                realign;
    logic [COL_W-1:0]    eff_col;
    logic [ROW_W-1:0]    eff_row;
    logic [ADDR_W-1:0]   eff_base;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            base_q      <= '0;
            wr_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            base_q      <= base_d;
            wr_q        <= wr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    // Next state: an sof pixel reuses the normal write path with the position forced to 0,
    // so a same-pixel eol realigns exactly like any other row end.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        base_d      = base_q;
        wr_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        err_line_d  = err_line_q & ~i_err_clr;
        err_frame_d = err_frame_q & ~i_err_clr;
        accept      = 1'b0;
        realign     = 1'b0;
        eff_col     = col_q;
        eff_row     = row_q;
        eff_base    = base_q;

        if (i_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (i_sof && i_capture_en) begin
                        accept   = 1'b1;
                        eff_col  = '0;
                        eff_row  = '0;
                        eff_base = '0;
                    end
                end
                S_ACTIVE: begin
                    if (i_sof) begin
                        err_frame_d = 1'b1;
                        if (i_capture_en) begin
                            accept   = 1'b1;
                            eff_col  = '0;
                            eff_row  = '0;
                            eff_base = '0;
                        end else begin
                            state_d = S_IDLE;
                            col_d   = '0;
                            row_d   = '0;
                            base_d  = '0;
                        end
                    end else begin
                        accept = 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_sof) begin
                        if (i_capture_en) begin
                            accept   = 1'b1;
                            eff_col  = '0;
                            eff_row  = '0;
                            eff_base = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (accept) begin
            state_d = S_ACTIVE;
            col_d   = eff_col;
            row_d   = eff_row;
            base_d  = eff_base;
            if (eff_col == COL_W'(H_ACTIVE)) begin
                err_line_d = 1'b1;
                realign    = i_eol;
            end else begin
                wr_d    = 1'b1;
                waddr_d = eff_base + ADDR_W'(eff_col);
                wdata_d = i_data;
                if (eff_col == COL_W'(H_ACTIVE - 1) && eff_row == ROW_W'(V_ACTIVE - 1)) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_DONE;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                end else if (i_eol) begin
                    realign = 1'b1;
                    if (eff_col != COL_W'(H_ACTIVE - 1)) begin
                        err_line_d = 1'b1;
                    end
                end else begin
                    col_d = eff_col + COL_W'(1);
                end
            end
            // A short final row ends the frame without a done pulse
            if (realign) begin
                col_d  = '0;
                row_d  = eff_row + ROW_W'(1);
                base_d = eff_base + ADDR_W'(H_ACTIVE);
                if (eff_row == ROW_W'(V_ACTIVE - 1)) begin
                    state_d = S_DONE;
                    row_d   = '0;
                    base_d  = '0;
                end
            end
        end
    end

    assign o_wr         = wr_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = cnt_q;
    assign o_err_line   = err_line_q;
    assign o_err_frame  = err_frame_q;

endmodule
